attn_qkv_loader: RTL and testbench

//  Upstream feeder for nvdla_attention. On start, fetches Q, then K, then V (seq_length rows each) from a

---
 rtl/attn_qkv_loader_if.sv | 43 ++++
 rtl/attn_qkv_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_attn_qkv_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_qkv_loader_if.sv
// Bus bundle between attn_qkv_loader, its read-only memory port and the q/k/v channels of nvdla_attention.
// master = loader side, slave = memory/consumer side.
interface attn_qkv_loader_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
);
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_ready;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data;

  logic              q_valid;
  logic [31:0]       q_addr;
  logic [DATA_W-1:0] q_data;
  logic              q_ready;

  logic              k_valid;
  logic [31:0]       k_addr;
  logic [DATA_W-1:0] k_data;
  logic              k_ready;

  logic              v_valid;
  logic [31:0]       v_addr;
  logic [DATA_W-1:0] v_data;
  logic              v_ready;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output q_valid, q_addr, q_data, input q_ready,
    output k_valid, k_addr, k_data, input k_ready,
    output v_valid, v_addr, v_data, input v_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  q_valid, q_addr, q_data, output q_ready,
    input  k_valid, k_addr, k_data, output k_ready,
    input  v_valid, v_addr, v_data, output v_ready
  );
endinterface

// File: rtl/attn_qkv_loader.sv
// Fetches Q, K, V rows from memory and streams them, in order, onto the q/k/v channels of nvdla_attention.
// Optional ATTN_LOADER_ZERO_PAD_EN: zero the lanes at or beyond head_dim in every streamed beat.
module attn_qkv_loader #(
  parameter int DATA_W     = 128,
  parameter int ELEM_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         seq_length,
  input  logic [31:0]         head_dim,
  input  logic [31:0]         q_base,
  input  logic [31:0]         k_base,
  input  logic [31:0]         v_base,
  attn_qkv_loader_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int LANES      = DATA_W / ELEM_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BEAT_BYTES = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_REQ_Q, S_REQ_K, S_REQ_V, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {TAG_Q, TAG_K, TAG_V} tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] addr;
  } tag_entry_t;

  typedef struct packed {
    tag_t              tag;
    logic [31:0]       addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  state_t state_q, state_d;

  logic [31:0]       seq_q, hd_q, k_base_q, v_base_q;
  logic [31:0]       row_q, elem_addr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic              busy_q, done_q, error_q;

  tag_entry_t        tq_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tq_wr_ptr, tq_rd_ptr;

  fifo_entry_t       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  f_wr_ptr, f_rd_ptr;
  logic [CNT_W-1:0]  f_count_q;

  logic              cfg_ok, start_acc, in_req, credit_ok, last_row;
  logic              req_fire, rsp_fire, head_valid, head_ready, pop;
  logic [CNT_W:0]    in_use;
  tag_t              cur_tag;
  fifo_entry_t       head, f_wdata;
  tag_entry_t        tq_wdata;
  logic [DATA_W-1:0] beat_d;

  assign cfg_ok    = (seq_length != 32'd0) && (head_dim != 32'd0) && (head_dim <= 32'(LANES));
  assign start_acc = start && (state_q == S_IDLE) && !busy_q;
  assign in_req    = (state_q == S_REQ_Q) || (state_q == S_REQ_K) || (state_q == S_REQ_V);

  // Slots in use = reads in flight plus beats waiting; a request needs a guaranteed FIFO slot.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, f_count_q};
  assign credit_ok = in_use < (CNT_W + 1)'(FIFO_DEPTH);
  assign last_row  = (row_q == seq_q - 32'd1);

  assign bus.rd_req_valid = in_req && credit_ok;
  assign bus.rd_req_addr  = req_addr_q;
  assign req_fire         = bus.rd_req_valid && bus.rd_req_ready;
  assign rsp_fire         = bus.rd_rsp_valid;

  assign head       = fifo_mem[f_rd_ptr];
  assign head_valid = (f_count_q != '0);
  assign pop        = head_valid && head_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cur_tag    = TAG_Q;
    head_ready = 1'b0;
    unique case (state_q)
      S_REQ_K: cur_tag = TAG_K;
      S_REQ_V: cur_tag = TAG_V;
      default: cur_tag = TAG_Q;
    endcase
    unique case (head.tag)
      TAG_Q:   head_ready = bus.q_ready;
      TAG_K:   head_ready = bus.k_ready;
      TAG_V:   head_ready = bus.v_ready;
      default: head_ready = 1'b0;
    endcase
  end

  // Channel outputs come straight from the FIFO head register; idle channels drive zeros.
  always_comb begin
    bus.q_valid = head_valid && (head.tag == TAG_Q);
    bus.k_valid = head_valid && (head.tag == TAG_K);
    bus.v_valid = head_valid && (head.tag == TAG_V);
    bus.q_addr  = bus.q_valid ? head.addr : 32'd0;
    bus.k_addr  = bus.k_valid ? head.addr : 32'd0;
    bus.v_addr  = bus.v_valid ? head.addr : 32'd0;
    bus.q_data  = bus.q_valid ? head.data : '0;
    bus.k_data  = bus.k_valid ? head.data : '0;
    bus.v_data  = bus.v_valid ? head.data : '0;
  end

`ifdef ATTN_LOADER_ZERO_PAD_EN
  logic [LANES-1:0] lane_mask_q, lane_mask_d;

  always_comb begin
    lane_mask_d = '0;
    for (int l = 0; l < LANES; l++) lane_mask_d[l] = (32'(l) < head_dim);
  end

  always_ff @(posedge clk) begin
    if (rst)            lane_mask_q <= '0;
    else if (start_acc) lane_mask_q <= lane_mask_d;
  end

  always_comb begin
    beat_d = bus.rd_rsp_data;
    for (int l = 0; l < LANES; l++)
      if (!lane_mask_q[l]) beat_d[l*ELEM_W +: ELEM_W] = '0;
  end
`else
  assign beat_d = bus.rd_rsp_data;
`endif

  always_comb begin
    tq_wdata      = '0;
    tq_wdata.tag  = cur_tag;
    tq_wdata.addr = elem_addr_q;
    f_wdata       = '0;
    f_wdata.tag   = tq_mem[tq_rd_ptr].tag;
    f_wdata.addr  = tq_mem[tq_rd_ptr].addr;
    f_wdata.data  = beat_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_acc) state_d = cfg_ok ? S_REQ_Q : S_DONE;
      S_REQ_Q: if (req_fire && last_row) state_d = S_REQ_K;
      S_REQ_K: if (req_fire && last_row) state_d = S_REQ_V;
      S_REQ_V: if (req_fire && last_row) state_d = S_DRAIN;
      S_DRAIN: if ((outstanding_q == '0) && (f_count_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q         <= '0;
      hd_q          <= '0;
      k_base_q      <= '0;
      v_base_q      <= '0;
      row_q         <= '0;
      elem_addr_q   <= '0;
      req_addr_q    <= '0;
      outstanding_q <= '0;
      tq_wr_ptr     <= '0;
      tq_rd_ptr     <= '0;
      f_wr_ptr      <= '0;
      f_rd_ptr      <= '0;
      f_count_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);

      if (start_acc) begin
        seq_q       <= seq_length;
        hd_q        <= head_dim;
        k_base_q    <= k_base;
        v_base_q    <= v_base;
        row_q       <= '0;
        elem_addr_q <= '0;
        req_addr_q  <= ADDR_W'(q_base);
        error_q     <= !cfg_ok;
        busy_q      <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end

      // Row walk: element address accumulates head_dim so no multiplier is needed.
      if (req_fire) begin
        tq_wr_ptr <= tq_wr_ptr + PTR_W'(1);
        if (last_row) begin
          row_q       <= '0;
          elem_addr_q <= '0;
          if (state_q == S_REQ_Q)      req_addr_q <= ADDR_W'(k_base_q);
          else if (state_q == S_REQ_K) req_addr_q <= ADDR_W'(v_base_q);
        end else begin
          row_q       <= row_q + 32'd1;
          elem_addr_q <= elem_addr_q + hd_q;
          req_addr_q  <= req_addr_q + ADDR_W'(BEAT_BYTES);
        end
      end

      if (rsp_fire) begin
        tq_rd_ptr <= tq_rd_ptr + PTR_W'(1);
        f_wr_ptr  <= f_wr_ptr + PTR_W'(1);
      end
      if (pop) f_rd_ptr <= f_rd_ptr + PTR_W'(1);

      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      unique case ({rsp_fire, pop})
        2'b10:   f_count_q <= f_count_q + CNT_W'(1);
        2'b01:   f_count_q <= f_count_q - CNT_W'(1);
        default: f_count_q <= f_count_q;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; cleared pointers and counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (req_fire) tq_mem[tq_wr_ptr]  <= tq_wdata;
    if (rsp_fire) fifo_mem[f_wr_ptr] <= f_wdata;
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_attn_qkv_loader.sv
// Directed bench for attn_qkv_loader: memory model with fixed latency, random consumer backpressure,
// scoreboard of expected Q/K/V beats, config-error, mid-run reset and lane-padding cases.
module tb_attn_qkv_loader;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 3000;
  localparam logic [31:0] QB = 32'h0001_0000;
  localparam logic [31:0] KB = 32'h0002_0000;
  localparam logic [31:0] VB = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seq_length, head_dim, q_base, k_base, v_base;
  logic        busy, done, error;

  int n_checks = 0;
  int n_pass   = 0;

  attn_qkv_loader_if #(.DATA_W(DATA_W), .ADDR_W(32)) bus ();

  attn_qkv_loader #(.DATA_W(DATA_W), .ELEM_W(16), .ADDR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seq_length (seq_length),
    .head_dim   (head_dim),
    .q_base     (q_base),
    .k_base     (k_base),
    .v_base     (v_base),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] raw_beat(input int mode, input int mat, input int row);
    logic [127:0] b;
    b = '0;
    for (int l = 0; l < 8; l++) begin
      case (mode)
        0:       if (l == row % 8) b[l*16 +: 16] = 16'h0100;
        1:       b[l*16 +: 16] = 16'hFFFF;
        default: b[l*16 +: 16] = {4'(mat + 1), 4'(l), 8'(row)};
      endcase
    end
    return b;
  endfunction

  function automatic logic [127:0] exp_beat(input int mode, input int mat, input int row, input int hd);
    logic [127:0] b;
    b = raw_beat(mode, mat, row);
`ifdef ATTN_LOADER_ZERO_PAD_EN
    for (int l = 0; l < 8; l++) if (l >= hd) b[l*16 +: 16] = 16'h0000;
`endif
    return b;
  endfunction

  function automatic logic [31:0] base_of(input int mat);
    return (mat == 0) ? QB : (mat == 1) ? KB : VB;
  endfunction

  // One full transaction: start pulse, memory model, consumer, scoreboard and end-of-run checks.
  task automatic run_case(input string nm, input int seq, input int hd, input int lat,
                          input int rdy_pct, input int mode, input int abort_at,
                          input bit poke_start, output int max_out);
    int rsp_due[$];
    logic [127:0] rsp_dat[$];
    logic [2:0]   vld, rdy, pvld, prdy;
    logic [31:0]  addr [3];
    logic [31:0]  paddr [3];
    logic [127:0] data [3];
    logic [127:0] pdata [3];
    int  req_n, beat_n, tb_out, done_cnt, done_cyc, onehot_viol, stall_viol, stalls;
    bit  exp_err, req_seen, finished;
    int  mat, row;

    exp_err = (seq == 0) || (hd == 0) || (hd > 8);
    req_n = 0; beat_n = 0; tb_out = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
    onehot_viol = 0; stall_viol = 0; stalls = 0; req_seen = 1'b0; finished = 1'b0;
    pvld = '0; prdy = '0;
    for (int c = 0; c < 3; c++) begin paddr[c] = '0; pdata[c] = '0; end

    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (abort_at >= 0 && req_n >= abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        bus.rd_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        check({nm, "/rst_valids"}, {bus.q_valid, bus.k_valid, bus.v_valid}, 3'b000);
        check({nm, "/rst_busy"}, busy, 1'b0);
        check({nm, "/rst_req"}, bus.rd_req_valid, 1'b0);
        rst = 1'b0;
        finished = 1'b1;
        break;
      end

      start = 1'b0;
      if (cyc == 0) begin
        seq_length = seq; head_dim = hd; q_base = QB; k_base = KB; v_base = VB;
        start = 1'b1;
      end else if (poke_start && cyc == 20) begin
        head_dim = 9;
        start = 1'b1;
      end else begin
        head_dim = hd;
      end

      if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
        void'(rsp_due.pop_front());
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_data  = rsp_dat.pop_front();
        tb_out--;
      end else begin
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_data  = '0;
      end

      for (int c = 0; c < 3; c++) rdy[c] = ($urandom_range(99) < rdy_pct);
      bus.q_ready = rdy[0]; bus.k_ready = rdy[1]; bus.v_ready = rdy[2];
      bus.rd_req_ready = 1'b1;
      #1;

      vld = {bus.v_valid, bus.k_valid, bus.q_valid};
      addr[0] = bus.q_addr; addr[1] = bus.k_addr; addr[2] = bus.v_addr;
      data[0] = bus.q_data; data[1] = bus.k_data; data[2] = bus.v_data;

      if (cyc == 1) begin
        check({nm, "/busy_after_start"}, busy, 1'b1);
        check({nm, "/error_after_start"}, error, exp_err);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({nm, "/busy_after_done"}, busy, 1'b0);
        check({nm, "/done_single"}, done, 1'b0);
        finished = 1'b1;
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({nm, "/error_at_done"}, error, exp_err);
      end

      if ((vld[0] + vld[1] + vld[2]) > 1) onehot_viol++;
      for (int c = 0; c < 3; c++) begin
        if (pvld[c] && !prdy[c]) begin
          stalls++;
          if (!vld[c] || addr[c] !== paddr[c] || data[c] !== pdata[c]) stall_viol++;
        end
      end

      if (bus.rd_req_valid) req_seen = 1'b1;
      if (bus.rd_req_valid && bus.rd_req_ready && seq > 0) begin
        mat = req_n / seq;
        row = req_n % seq;
        check({nm, "/req_addr"}, bus.rd_req_addr, base_of(mat) + 32'(row * 16));
        rsp_due.push_back(cyc + lat);
        rsp_dat.push_back(raw_beat(mode, mat, row));
        req_n++;
        tb_out++;
        if (tb_out > max_out) max_out = tb_out;
      end

      for (int c = 0; c < 3; c++) begin
        if (vld[c] && rdy[c] && seq > 0) begin
          mat = beat_n / seq;
          row = beat_n % seq;
          check({nm, "/beat_chan"}, c, mat);
          check({nm, "/beat_addr"}, addr[c], 32'(row * hd));
          check({nm, "/beat_data"}, data[c], exp_beat(mode, mat, row, hd));
          beat_n++;
        end
      end

      pvld = vld; prdy = rdy;
      for (int c = 0; c < 3; c++) begin paddr[c] = addr[c]; pdata[c] = data[c]; end
    end

    start = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.q_ready = 1'b1; bus.k_ready = 1'b1; bus.v_ready = 1'b1;
    if (!finished) begin
      check({nm, "/timeout"}, 1'b0, 1'b1);
    end else if (abort_at < 0) begin
      check({nm, "/done_count"}, done_cnt, 1);
      check({nm, "/onehot"}, onehot_viol, 0);
      check({nm, "/stall_stable"}, stall_viol, 0);
      check({nm, "/outstanding_max"}, (max_out <= DEPTH), 1'b1);
      if (exp_err) begin
        check({nm, "/err_done_lat"}, done_cyc, 2);
        check({nm, "/err_no_req"}, req_seen, 1'b0);
      end else begin
        check({nm, "/beat_total"}, beat_n, 3 * seq);
      end
      if (rdy_pct < 100) check({nm, "/stalls_seen"}, (stalls > 0), 1'b1);
    end
  endtask

  initial begin
    int mo;
    rst = 1'b1;
    start = 1'b0;
    seq_length = '0; head_dim = '0; q_base = '0; k_base = '0; v_base = '0;
    bus.rd_req_ready = 1'b1;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.q_ready = 1'b1; bus.k_ready = 1'b1; bus.v_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset/valids", {bus.q_valid, bus.k_valid, bus.v_valid, bus.rd_req_valid}, 4'b0000);
    check("reset/status", {busy, done, error}, 3'b000);
    check("reset/addr", bus.rd_req_addr, 32'd0);
    rst = 1'b0;

    run_case("t1_identity", 4, 4, 2, 100, 0, -1, 1'b0, mo);
    run_case("t2_credit", 16, 8, 10, 100, 2, -1, 1'b0, mo);
    check("t2_credit/max_reached", mo, DEPTH);
    run_case("t3_backpressure", 8, 5, 3, 30, 2, -1, 1'b1, mo);
    run_case("t4_hd9", 4, 9, 2, 100, 2, -1, 1'b0, mo);
    run_case("t4_seq0", 0, 4, 2, 100, 2, -1, 1'b0, mo);
    run_case("t4_recover", 2, 1, 1, 100, 2, -1, 1'b0, mo);
    run_case("t5_abort", 6, 2, 2, 100, 2, 7, 1'b0, mo);
    run_case("t5_clean", 4, 3, 4, 60, 2, -1, 1'b0, mo);
    run_case("t6_pad", 3, 3, 1, 100, 1, -1, 1'b0, mo);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
